// File: rtl/lsu_dtcm.sv
// Load/store unit between the execute stage and the data TCM: lane steering, read alignment/extension.
// MISALIGN_SPLIT_EN: when defined, word-crossing accesses are split into two TCM accesses; otherwise they error.
module lsu_dtcm #(
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    localparam int IDX_W = MEM_ADDR_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESP   = 2'd1,
        S_SPLIT2 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  w_base;
    logic [7:0]  w_en;
    logic        w_cross;
    logic        w_accept;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic        r_cross;

    logic [31:0] w_aligned;
    logic [31:0] w_extended;

    always_comb begin
        case (i_req_size)
            2'd0:    w_base = 4'b0001;
            2'd1:    w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
    end

    // Upper nibble of the shifted enable vector belongs to the next word.
    assign w_en     = {4'b0000, w_base} << i_req_addr[1:0];
    assign w_cross  = |w_en[7:4];
    assign w_accept = i_req_valid & (r_state == S_IDLE) & ~i_reset;
    assign o_req_ready = (r_state == S_IDLE) & ~i_reset;

`ifdef MISALIGN_SPLIT_EN
    logic [29:0]      r_word_addr;
    logic [3:0]       r_wen_hi;
    logic [31:0]      r_wdata_hi;
    logic [31:0]      r_lo_buf;
    logic [5:0]       w_hi_shamt;
    logic [IDX_W-1:0] w_idx_next;
    logic [31:0]      w_addr2;
    logic [63:0]      w_merge;

    assign w_hi_shamt = 6'd32 - {1'b0, i_req_addr[1:0], 3'b000};
    assign w_idx_next = r_word_addr[IDX_W-1:0] + IDX_W'(1);

    // Second word wraps inside the TCM window; bits above it pass through.
    generate
        if (MEM_ADDR_BITS < 32) begin : g_addr_hi
            assign w_addr2 = {r_word_addr[29:IDX_W], w_idx_next, 2'b00};
        end else begin : g_addr_full
            assign w_addr2 = {w_idx_next, 2'b00};
        end
    endgenerate

    assign w_merge   = r_cross ? {i_mem_rdata, r_lo_buf} : {32'h0000_0000, i_mem_rdata};
    assign w_aligned = w_merge[{r_off, 3'b000} +: 32];
`else
    assign w_aligned = i_mem_rdata >> {r_off, 3'b000};
`endif

    always_comb begin
        case (r_size)
            2'd0:    w_extended = {{24{~r_unsigned & w_aligned[7]}}, w_aligned[7:0]};
            2'd1:    w_extended = {{16{~r_unsigned & w_aligned[15]}}, w_aligned[15:0]};
            default: w_extended = w_aligned;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        o_mem_addr   = {i_req_addr[31:2], 2'b00};
        o_mem_wen    = 4'b0000;
        o_mem_wdata  = i_req_wdata << {i_req_addr[1:0], 3'b000};
        o_rsp_valid  = 1'b0;
        o_rsp_err    = 1'b0;
        o_rsp_rdata  = 32'h0000_0000;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef MISALIGN_SPLIT_EN
                    w_state_next = w_cross ? S_SPLIT2 : S_RESP;
                    if (i_req_we) begin
                        o_mem_wen = w_en[3:0];
                    end
`else
                    w_state_next = S_RESP;
                    if (i_req_we && !w_cross) begin
                        o_mem_wen = w_en[3:0];
                    end
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            S_SPLIT2: begin
                w_state_next = S_RESP;
                o_mem_addr   = w_addr2;
                o_mem_wdata  = r_wdata_hi;
                if (r_we && !i_reset) begin
                    o_mem_wen = r_wen_hi;
                end
            end
`endif
            S_RESP: begin
                w_state_next = S_IDLE;
                o_rsp_valid  = ~i_reset;
`ifdef MISALIGN_SPLIT_EN
                if (!i_reset && !r_we) begin
                    o_rsp_rdata = w_extended;
                end
`else
                o_rsp_err = ~i_reset & r_cross;
                if (!i_reset && !r_we && !r_cross) begin
                    o_rsp_rdata = w_extended;
                end
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off      <= 2'd0;
            r_cross    <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            r_word_addr <= 30'd0;
            r_wen_hi    <= 4'b0000;
            r_wdata_hi  <= 32'h0000_0000;
            r_lo_buf    <= 32'h0000_0000;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we       <= i_req_we;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_off      <= i_req_addr[1:0];
                r_cross    <= w_cross;
`ifdef MISALIGN_SPLIT_EN
                r_word_addr <= i_req_addr[31:2];
                r_wen_hi    <= w_en[7:4];
                r_wdata_hi  <= i_req_wdata >> w_hi_shamt;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            // First word's read data arrives while the second address is on the bus.
            if (r_state == S_SPLIT2) begin
                r_lo_buf <= i_mem_rdata;
            end
`endif
        end
    end
endmodule
